// File: rtl/ethernet_pkg.sv
// ethernet_pkg: shared state encoding, MII framing nibbles and CRC-32 constants for the Ethernet RX path.
package ethernet_pkg;

    typedef enum logic [2:0] {IDLE, PREAMBLE, LOW, HIGH, DROP} state_t;

    localparam logic [3:0]  PREAMBLE_NIBBLE         = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE              = 4'hD;
    localparam logic [31:0] CRC_POLY                = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT                = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE             = 32'hC704DD7B;
    localparam int          DEFAULT_MAX_FRAME_BYTES = 1518;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

endpackage

// File: rtl/ethernet_crc32.sv
// ethernet_crc32: reflected CRC-32 register advanced one MII nibble per enable, low bit first.
module ethernet_crc32
    import ethernet_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        nibble_en,
    input  logic [3:0]  nibble,
    output logic [31:0] crc
);

    logic [31:0] crc_next;

    always_comb begin
        crc_next = crc ^ {28'd0, nibble};
        for (int i = 0; i < 4; i++)
            crc_next = crc_next[0] ? (crc_next >> 1) ^ reflect32(CRC_POLY) : crc_next >> 1;
    end

    always_ff @(posedge clk) begin
        if (reset || clear)
            crc <= CRC_INIT;
        else if (nibble_en)
            crc <= crc_next;
    end

endmodule

// File: rtl/ethernet_rx_frame.sv
// ethernet_rx_frame: hunts preamble/SFD on MII nibbles, assembles bytes and reports frame end/length/error.
// Define ETHERNET_RX_FCS_CHECK_EN to also flag frames whose FCS fails the CRC-32 residue test.
module ethernet_rx_frame
    import ethernet_pkg::*;
#(
    parameter int MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        nibble_ready,
    input  logic [3:0]  nibble,
    input  logic        ethernet_rx_dv,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        frame_start,
    output logic        frame_end,
    output logic        frame_error,
    output logic [10:0] frame_length
);

    localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_BYTES);

    state_t      state, mid, state_n;
    logic        dv_meta, dv_s, seen_5, seen_5_n;
    logic        err_q, err_n, started, started_n, frame_error_q;
    logic [3:0]  stored;
    logic [10:0] count, count_n, count_inc;
    logic        take_byte, overflow, emit, end_frame, end_err;

    assign take_byte = state == HIGH && nibble_ready;
    assign count_inc = &count ? count : count + 11'd1;
    assign overflow  = take_byte && count_inc > MAX_LEN;
    assign emit      = take_byte && !overflow;
    assign count_n   = take_byte ? count_inc : count;
    assign err_n     = err_q | overflow;
    assign started_n = started | emit;

    // A nibble arriving with the dv fall is consumed first (mid), then end handling runs on mid.
    always_comb begin
        mid      = state;
        seen_5_n = state == IDLE ? 1'b0 : seen_5;
        if (nibble_ready) begin
            case (state)
                PREAMBLE: begin
                    if (nibble == PREAMBLE_NIBBLE)
                        seen_5_n = 1'b1;
                    else
                        mid = nibble == SFD_NIBBLE && seen_5 ? LOW : DROP;
                end
                LOW:     mid = HIGH;
                HIGH:    mid = overflow ? DROP : LOW;
                default: mid = state;
            endcase
        end
        state_n   = mid == IDLE ? (start && dv_s ? PREAMBLE : IDLE) : (dv_s ? mid : IDLE);
        end_frame = !dv_s && (mid == LOW || mid == HIGH || (mid == DROP && started_n));
        end_err   = err_n || mid == HIGH || count_n == '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            dv_meta       <= 1'b0;
            dv_s          <= 1'b0;
            seen_5        <= 1'b0;
            stored        <= '0;
            err_q         <= 1'b0;
            started       <= 1'b0;
            count         <= '0;
            byte_valid    <= 1'b0;
            byte_data     <= '0;
            frame_start   <= 1'b0;
            frame_end     <= 1'b0;
            frame_error_q <= 1'b0;
            frame_length  <= '0;
        end else begin
            dv_meta       <= ethernet_rx_dv;
            dv_s          <= dv_meta;
            state         <= state_n;
            seen_5        <= seen_5_n;
            if (state == LOW && nibble_ready) stored <= nibble;
            err_q         <= state == IDLE ? 1'b0 : err_n;
            started       <= state == IDLE ? 1'b0 : started_n;
            count         <= state == IDLE ? '0 : count_n;
            byte_valid    <= emit;
            if (emit) byte_data <= {nibble, stored};
            frame_start   <= emit && !started;
            frame_end     <= end_frame;
            frame_error_q <= end_frame && end_err;
            if (end_frame) frame_length <= count_n;
        end
    end

`ifdef ETHERNET_RX_FCS_CHECK_EN
    logic [31:0] crc;

    ethernet_crc32 u_crc (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == PREAMBLE),
        .nibble_en ((state == LOW || state == HIGH) && nibble_ready),
        .nibble    (nibble),
        .crc       (crc)
    );

    // The register runs reflected, so the residue is compared bit-reversed.
    assign frame_error = frame_error_q | (frame_end & (crc != reflect32(CRC_RESIDUE)));
`else
    assign frame_error = frame_error_q;
`endif

endmodule

// File: tb/tb_ethernet_rx_frame.sv
// tb_ethernet_rx_frame: directed self-checking bench for ethernet_rx_frame (default MAX_FRAME_BYTES).
`timescale 1ns/1ps
module tb_ethernet_rx_frame;

    logic        clk = 0, reset = 1, start = 1, nibble_ready = 0, ethernet_rx_dv = 0;
    logic [3:0]  nibble = 0;
    logic        byte_valid, frame_start, frame_end, frame_error;
    logic [7:0]  byte_data;
    logic [10:0] frame_length;

    int          tests = 0, fails = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  tx[$];
    int          n_start = 0, n_end = 0, start_idx = -1;
    logic        last_err = 0;
    logic [10:0] last_len = 0;
    int          q0 = 0, e0 = 0, s0 = 0;
    logic [31:0] fcs;

`ifdef ETHERNET_RX_FCS_CHECK_EN
    localparam logic FLIP_ERR = 1'b1;
`else
    localparam logic FLIP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    ethernet_rx_frame dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .nibble_ready   (nibble_ready),
        .nibble         (nibble),
        .ethernet_rx_dv (ethernet_rx_dv),
        .byte_valid     (byte_valid),
        .byte_data      (byte_data),
        .frame_start    (frame_start),
        .frame_end      (frame_end),
        .frame_error    (frame_error),
        .frame_length   (frame_length)
    );

    always @(negedge clk) begin
        if (frame_start) begin
            n_start++;
            start_idx = rx_q.size();
        end
        if (byte_valid) rx_q.push_back(byte_data);
        if (frame_end) begin
            n_end++;
            last_err = frame_error;
            last_len = frame_length;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mark();
        q0 = rx_q.size();
        e0 = n_end;
        s0 = n_start;
    endtask

    task automatic nib(input logic [3:0] n);
        @(posedge clk); #1;
        nibble = n;
        nibble_ready = 1;
        @(posedge clk); #1;
        nibble_ready = 0;
    endtask

    task automatic dv_up();
        ethernet_rx_dv = 1;
        repeat (4) @(posedge clk);
    endtask

    task automatic dv_down();
        @(posedge clk); #1;
        ethernet_rx_dv = 0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic preamble();
        repeat (15) nib(4'h5);
        nib(4'hD);
    endtask

    task automatic bytes_out();
        foreach (tx[i]) begin
            nib(tx[i][3:0]);
            nib(tx[i][7:4]);
        end
    endtask

    task automatic frame();
        mark();
        dv_up();
        preamble();
        bytes_out();
        dv_down();
    endtask

    task automatic fill(input int n, input int base);
        tx.delete();
        for (int i = 0; i < n; i++) tx.push_back(8'(base + i));
    endtask

    task automatic check_rx(input string tag, input int n);
        int bad = 0;
        check({tag, " byte count"}, rx_q.size() - q0, n);
        for (int i = 0; i < n && q0 + i < rx_q.size(); i++)
            if (rx_q[q0+i] !== tx[i]) bad++;
        check({tag, " bad bytes"}, bad, 0);
    endtask

    task automatic check_end(input string tag, input int ends, input logic err, input int len);
        check({tag, " frame_end count"}, n_end - e0, ends);
        check({tag, " frame_error"}, last_err, err);
        check({tag, " frame_length"}, last_len, len);
    endtask

    function automatic logic [31:0] fcs_of_tx();
        logic [31:0] c = '1;
        foreach (tx[i]) begin
            c ^= {24'd0, tx[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
        end
        return ~c;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset outputs", {byte_valid, byte_data, frame_start, frame_end, frame_error, frame_length}, 0);
        reset = 0;
        @(posedge clk); #1;

        fill(64, 0);
        frame();
        check_rx("64B", 64);
        check("64B frame_start count", n_start - s0, 1);
        check("64B frame_start position", start_idx, q0);
        check_end("64B", 1, 0, 64);

        fill(4, 8'h40);
        mark();
        dv_up();
        nib(4'h5); nib(4'h5); nib(4'hA);
        bytes_out();
        dv_down();
        check("bad preamble bytes", rx_q.size() - q0, 0);
        check("bad preamble frame_end", n_end - e0, 0);
        fill(8, 8'h80);
        frame();
        check_rx("after bad preamble", 8);
        check_end("after bad preamble", 1, 0, 8);

        fill(4, 8'h10);
        mark();
        dv_up();
        preamble();
        bytes_out();
        nib(4'h7);
        dv_down();
        check_rx("odd nibbles", 4);
        check_end("odd nibbles", 1, 1, 4);

        tx.delete();
        frame();
        check("empty frame_start count", n_start - s0, 0);
        check_end("empty", 1, 1, 0);

        fill(1600, 0);
        frame();
        check_rx("oversize", 1518);
        check_end("oversize", 1, 1, 1519);
        repeat (20) @(posedge clk);
        #1;
        check("frame_length held", frame_length, 1519);

        fill(10, 8'h20);
        mark();
        dv_up();
        preamble();
        bytes_out();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;
        check("mid reset outputs", {byte_valid, byte_data, frame_start, frame_end, frame_error, frame_length}, 0);
        reset = 0;
        ethernet_rx_dv = 0;
        repeat (6) @(posedge clk);
        #1;
        check_rx("before reset", 10);
        check("mid reset frame_end", n_end - e0, 0);
        fill(5, 8'hA0);
        frame();
        check_rx("after reset", 5);
        check_end("after reset", 1, 0, 5);

        start = 0;
        fill(3, 1);
        frame();
        check("start low bytes", rx_q.size() - q0, 0);
        check("start low frame_end", n_end - e0, 0);
        start = 1;
        fill(6, 8'h60);
        mark();
        dv_up();
        preamble();
        start = 0;
        bytes_out();
        dv_down();
        start = 1;
        check_rx("start dropped mid-frame", 6);
        check_end("start dropped mid-frame", 1, 0, 6);

        fill(60, 8'h33);
        fcs = fcs_of_tx();
        for (int k = 0; k < 4; k++) tx.push_back(fcs[8*k +: 8]);
        frame();
        check_rx("good fcs", 64);
        check_end("good fcs", 1, 0, 64);
        tx[61] = tx[61] ^ 8'h04;
        frame();
        check_end("flipped fcs", 1, FLIP_ERR, 64);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
